alu_iterative: RTL and testbench
================================

// Module: alu_iterative
// PURPOSE
//  Execute-stage ALU, directly downstream of ALU control: consumes the 4-bit ALU
//  control code plus two operands, returns result, zero flag and branch decision.
//  Logic/arith ops complete in 1 cycle; shifts run iteratively, 1 bit per cycle.
//  Valid/ready handshake on both sides so the pipeline can stall around it.
// PARAMETERS
//  WIDTH    32  operand/result width; power of two, >= 8
//  SHW      $clog2(WIDTH)  shift-amount width (derived localparam, not overridable)
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      synchronous, active-high
//  in_valid      in   1      operation request
//  in_ready      out  1      block can accept request this cycle
//  alu_ctrl      in   4      op code (table below)
//  shift_arith   in   1      SR only: 1 = arithmetic, 0 = logical
//  operand_a     in   WIDTH  rs1 / base
//  operand_b     in   WIDTH  rs2 / imm; shamt = operand_b[SHW-1:0]
//  out_valid     out  1      result/flags valid
//  out_ready     in   1      consumer takes result
//  result        out  WIDTH  op result; 0 for branch codes
//  zero          out  1      result == 0
//  branch_taken  out  1      branch comparison outcome; 0 for non-branch codes
//  busy          out  1      state != IDLE
// BEHAVIOUR
//  Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SR, 0101 XOR, 0110 SUB,
//   1000 EQ, 1001 NE, 1010 LT(signed), 1011 GE(signed), 1100 LTU, 1101 GEU.
//   Any other code executes as ADD. Add/sub wrap modulo 2^WIDTH, no flags.
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, branch_taken=0, busy=0.
//  FSM IDLE -> (accept = in_valid & in_ready):
//   non-shift, or shift with shamt==0 -> DONE; outputs registered, out_valid next cycle.
//   shift with shamt!=0 -> SHIFT; latch a, shamt counter, direction, arith bit.
//  SHIFT: one 1-bit shift per cycle, counter decrements; at counter==1 the final
//   shift is applied and state -> DONE. Shift latency = 1 + shamt cycles to out_valid.
//   SRA fills with latched sign bit; SRL/SLL fill with 0.
//  DONE: out_valid=1; outputs stable until out_ready; out_valid & out_ready -> IDLE.
//  in_ready = (state==IDLE); no overlap of requests (max 1 op in flight).
//  Operands sampled only at accept; changes while busy are ignored.
//  zero computed on final result; for branch codes result=0 so zero=1.
//  reset has priority over everything, including mid-SHIFT and held DONE: op discarded.
//  out_ready while not out_valid: ignored.
// CONFIGURATION
//  ALU_FAST_SHIFT_EN defined: shifts use a single-cycle barrel shifter, all ops
//   take IDLE -> DONE (latency 1); SHIFT state and counter not generated.
//  Undefined (default): iterative shifter as above, latency 1 + shamt.
//  Handshake, codes, flags and reset values identical in both builds.
// STRUCTURE
//  Package alu_pkg: ALU_AND..ALU_GEU 4-bit code localparams (shared with ALU
//   control), alu_state_t enum {IDLE, SHIFT, DONE}.
//  Sub-module alu_branch_cmp: combinational (a, b, code) -> taken; reused by
//   any future early-branch resolution. Everything else in alu_iterative.
// TESTING
//  reset held 2 cycles mid-SHIFT -> IDLE, out_valid=0, in_ready=1, busy=0 next cycle.
//  ADD a=0xFFFFFFFF b=1 -> out_valid 1 cycle after accept, result=0, zero=1.
//  SUB a=5 b=7 -> result=0xFFFFFFFE, zero=0; code 0111 a=2 b=3 -> result=5 (ADD).
//  SR arith a=0x80000000 b=4 -> result=0xF8000000 after 5 cycles; SRL same -> 0x08000000.
//  SLL a=1 b=0x23 (shamt=3) -> 0x8 in 4 cycles; shamt 0 -> result=a in 1 cycle.
//  LT a=-1 b=1 -> taken=1; LTU same -> 0; out_ready=0 for 3 cycles -> outputs held,
//   in_ready=0, second in_valid not accepted until after handoff.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit operation codes (also used by ALU control)
// and the iterative ALU's state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_NE  = 4'b1001;
  localparam logic [3:0] ALU_LT  = 4'b1010;
  localparam logic [3:0] ALU_GE  = 4'b1011;
  localparam logic [3:0] ALU_LTU = 4'b1100;
  localparam logic [3:0] ALU_GEU = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_branch_cmp.sv
// Combinational branch comparator: decides taken for the six branch codes,
// 0 for every other code. Kept separate so early branch resolution can reuse it.
module alu_branch_cmp
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       code,
  output logic             taken
);

  always_comb begin
    taken = 1'b0;
    case (code)
      ALU_EQ:  taken = (a == b);
      ALU_NE:  taken = (a != b);
      ALU_LT:  taken = ($signed(a) <  $signed(b));
      ALU_GE:  taken = ($signed(a) >= $signed(b));
      ALU_LTU: taken = (a <  b);
      ALU_GEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU with valid/ready handshakes; shifts run 1 bit per cycle
// unless ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic             shift_arith,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] aluOut;
  logic             takenOut;
  logic             isShift;
  logic [SHW-1:0]   shamt;

  assign shamt   = operand_b[SHW-1:0];
  assign isShift = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SR);

  alu_branch_cmp #(.WIDTH(WIDTH)) uBranchCmp (
    .a     (operand_a),
    .b     (operand_b),
    .code  (alu_ctrl),
    .taken (takenOut)
  );

  // Single-cycle result; in the iterative build a shift only lands here with shamt 0.
  always_comb begin
    aluOut = operand_a + operand_b;
    case (alu_ctrl)
      ALU_AND: aluOut = operand_a & operand_b;
      ALU_OR:  aluOut = operand_a | operand_b;
      ALU_XOR: aluOut = operand_a ^ operand_b;
      ALU_SUB: aluOut = operand_a - operand_b;
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL: aluOut = operand_a << shamt;
      ALU_SR:  aluOut = shift_arith ? WIDTH'($signed(operand_a) >>> shamt)
                                    : operand_a >> shamt;
`else
      ALU_SLL, ALU_SR: aluOut = operand_a;
`endif
      ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU: aluOut = '0;
      default: aluOut = operand_a + operand_b;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic [WIDTH-1:0] shReg_q, shReg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             arith_q, arith_d;
  logic [WIDTH-1:0] shStep;

  assign shStep = left_q ? {shReg_q[WIDTH-2:0], 1'b0}
                         : {arith_q & shReg_q[WIDTH-1], shReg_q[WIDTH-1:1]};
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    taken_d  = taken_q;
`ifndef ALU_FAST_SHIFT_EN
    shReg_d  = shReg_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    arith_d  = arith_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
          if (isShift && (shamt != '0)) begin
            state_d = SHIFT;
            shReg_d = operand_a;
            cnt_d   = shamt;
            left_d  = (alu_ctrl == ALU_SLL);
            arith_d = shift_arith;
          end else
`endif
          begin
            state_d  = DONE;
            result_d = aluOut;
            zero_d   = (aluOut == '0);
            taken_d  = takenOut;
          end
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      // The last step writes straight into the result so out_valid follows at once.
      SHIFT: begin
        cnt_d   = cnt_q - SHW'(1);
        shReg_d = shStep;
        if (cnt_q == SHW'(1)) begin
          state_d  = DONE;
          result_d = shStep;
          zero_d   = (shStep == '0);
          taken_d  = 1'b0;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      taken_q  <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      shReg_q  <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      taken_q  <= taken_d;
`ifndef ALU_FAST_SHIFT_EN
      shReg_q  <= shReg_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
`endif
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = (state_q == DONE);
  assign result       = result_q;
  assign zero         = zero_q;
  assign branch_taken = taken_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Randomized self-checking bench for alu_iterative against a plain-arithmetic
// reference model, plus directed corner cases and a mid-shift reset.
module tb_alu_iterative;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic        shift_arith;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        branch_taken;
  logic        busy;

  int testCount = 0;
  int failCount = 0;

  alu_iterative #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_ctrl     (alu_ctrl),
    .shift_arith  (shift_arith),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .branch_taken (branch_taken),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the opcode table.
  function automatic void refModel(input logic [3:0] code, input logic arith,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic t, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'd0;
    t   = 1'b0;
    lat = 1;
    case (code)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: begin r = a << sh; lat = 1 + sh; end
      4'b0100: begin
        r   = arith ? 32'($signed(a) >>> sh) : (a >> sh);
        lat = 1 + sh;
      end
      4'b0101: r = a ^ b;
      4'b0110: r = a - b;
      4'b1000: t = (a == b);
      4'b1001: t = (a != b);
      4'b1010: t = ($signed(a) < $signed(b));
      4'b1011: t = ($signed(a) >= $signed(b));
      4'b1100: t = (a < b);
      4'b1101: t = (a >= b);
      default: r = a + b;
    endcase
`ifdef ALU_FAST_SHIFT_EN
    lat = 1;
`endif
  endfunction

  task automatic waitReady();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [3:0] code, input logic arith,
                               input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] expR;
    logic        expT;
    int          expLat;
    int          lat;
    refModel(code, arith, a, b, expR, expT, expLat);
    @(negedge clk);
    waitReady();
    in_valid    = 1'b1;
    alu_ctrl    = code;
    shift_arith = arith;
    operand_a   = a;
    operand_b   = b;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    operand_a   = $urandom;
    operand_b   = $urandom;
    shift_arith = ~arith;
    lat = 1;
    while (!out_valid && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("result", result, expR);
    checkOutput("zero", {31'd0, zero}, {31'd0, expR == 32'd0});
    checkOutput("taken", {31'd0, branch_taken}, {31'd0, expT});
    checkOutput("busy_done", {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_result", result, expR);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("handoff_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("handoff_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_result"}, result, 32'd0);
    checkOutput({tag, "_zero"}, {31'd0, zero}, 32'd0);
    checkOutput({tag, "_taken"}, {31'd0, branch_taken}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rc;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_ctrl    = 4'd0;
    shift_arith = 1'b0;
    operand_a   = 32'd0;
    operand_b   = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkIdleReset("reset");

    applyStimulus(4'b0010, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus(4'b0110, 1'b0, 32'd5, 32'd7, 0);
    applyStimulus(4'b0111, 1'b0, 32'd2, 32'd3, 0);
    applyStimulus(4'b0100, 1'b1, 32'h8000_0000, 32'd4, 0);
    applyStimulus(4'b0100, 1'b0, 32'h8000_0000, 32'd4, 0);
    applyStimulus(4'b0011, 1'b0, 32'd1, 32'h23, 0);
    applyStimulus(4'b0011, 1'b0, 32'h1234_5678, 32'h20, 0);
    applyStimulus(4'b0100, 1'b1, 32'h8000_0001, 32'd31, 1);
    applyStimulus(4'b1010, 1'b0, 32'hFFFF_FFFF, 32'd1, 3);
    applyStimulus(4'b1100, 1'b0, 32'hFFFF_FFFF, 32'd1, 3);

    // Reset held for two cycles while a long shift is in progress.
    @(negedge clk);
    waitReady();
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0100;
    operand_a = 32'h8000_0000;
    operand_b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkIdleReset("mid_shift_reset");
    repeat (3) @(negedge clk);
    checkOutput("no_late_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 150; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'd0;
      applyStimulus(rc, 1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
